tmds_pll_rst_seq: RTL and testbench

// - Lock supervisor and reset sequencer for the TMDS PLL on the 50 MHz board clock.
// - Synchronises and qualifies the PLL lock, and drives the PLL reset pin with retry-on-timeout.
// - Releases the serializer-domain reset first, then the pixel-domain reset.
// - Sits directly downstream of the TMDS PLL: consumes its lock and feeds its RESET input;

---
 rtl/tmds_pll_rst_seq.sv | 165 ++++++++++++++++
 tb/tb_tmds_pll_rst_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_pll_rst_seq.sv
// Lock supervisor and reset sequencer for the TMDS PLL (clkin domain).
// Optional lock-loss counter enabled by defining TMDS_PLL_RST_SEQ_LOSS_CNT_EN.
module tmds_pll_rst_seq #(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned SER_TO_PIX_CYC   = 8,
  parameter int unsigned MAX_RETRY        = 4,
  parameter int unsigned CNT_W            = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock_i,
  output logic       pll_rst_o,
  output logic       ser_rst_o,
  output logic       pix_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lock_loss_cnt_o
);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_REL_SER,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] S2P_LAST    = CNT_W'(SER_TO_PIX_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       MAX_R       = 4'(MAX_RETRY);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       retry_nx, retry_inc;
  logic             lock_m, lock_s;
  logic             pll_rst_nx, ser_rst_nx, pix_rst_nx, ready_nx, fail_nx;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock_i;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state       <= ST_PLL_RST;
      cnt         <= '0;
      retry_cnt_o <= '0;
      pll_rst_o   <= 1'b1;
      ser_rst_o   <= 1'b1;
      pix_rst_o   <= 1'b1;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      retry_cnt_o <= retry_nx;
      pll_rst_o   <= pll_rst_nx;
      ser_rst_o   <= ser_rst_nx;
      pix_rst_o   <= pix_rst_nx;
      ready_o     <= ready_nx;
      fail_o      <= fail_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    retry_nx  = retry_cnt_o;
    retry_inc = (retry_cnt_o == 4'hF) ? 4'hF : retry_cnt_o + 4'd1;
    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT_LOCK;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          cnt_nx   = '0;
          state_nx = ST_STABLE;
        end else if (cnt == TO_LAST) begin
          retry_nx = retry_inc;
          cnt_nx   = '0;
          state_nx = (retry_inc == MAX_R) ? ST_FAIL : ST_PLL_RST;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_REL_SER;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_REL_SER: begin
        // Lock loss wins over a release falling on the same cycle.
        if (!lock_s) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT_LOCK;
        end else if (cnt == S2P_LAST) begin
          cnt_nx   = '0;
          retry_nx = '0;
          state_nx = ST_RUN;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT_LOCK;
        end
      end
      ST_FAIL: begin
        state_nx = ST_FAIL;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_PLL_RST;
      end
    endcase

    // Outputs are decoded from the next state so they register together with it.
    pll_rst_nx = (state_nx == ST_PLL_RST);
    ser_rst_nx = !((state_nx == ST_REL_SER) || (state_nx == ST_RUN));
    pix_rst_nx = (state_nx != ST_RUN);
    ready_nx   = (state_nx == ST_RUN);
    fail_nx    = (state_nx == ST_FAIL);
  end

`ifdef TMDS_PLL_RST_SEQ_LOSS_CNT_EN
  logic loss_ev;
  assign loss_ev = ((state == ST_REL_SER) || (state == ST_RUN)) && !lock_s;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_loss_cnt_o <= '0;
    end else if (loss_ev && (lock_loss_cnt_o != 8'hFF)) begin
      lock_loss_cnt_o <= lock_loss_cnt_o + 8'd1;
    end
  end
`else
  assign lock_loss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_tmds_pll_rst_seq.sv
// Bench for tmds_pll_rst_seq: directed scenarios plus randomized lock_i,
// checked every cycle against a consecutive-lock-count model.
module tb_tmds_pll_rst_seq;
  localparam int unsigned P    = 4;
  localparam int unsigned TO   = 60;
  localparam int unsigned S    = 20;
  localparam int unsigned T    = 5;
  localparam int unsigned MAXR = 3;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       lock_i = 1'b0;
  logic       pll_rst_o, ser_rst_o, pix_rst_o, ready_o, fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clkin = ~clkin;

  tmds_pll_rst_seq #(
    .RST_PULSE_CYC   (P),
    .LOCK_TIMEOUT_CYC(TO),
    .STABLE_CYC      (S),
    .SER_TO_PIX_CYC  (T),
    .MAX_RETRY       (MAXR),
    .CNT_W           (8)
  ) dut (
    .clkin          (clkin),
    .reset          (reset),
    .lock_i         (lock_i),
    .pll_rst_o      (pll_rst_o),
    .ser_rst_o      (ser_rst_o),
    .pix_rst_o      (pix_rst_o),
    .ready_o        (ready_o),
    .fail_o         (fail_o),
    .retry_cnt_o    (retry_cnt_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: q = consecutive qualified lock samples since seeking restarted,
  // w = consecutive unlocked samples while seeking, pulse_left = PLL reset cycles left.
  int m_s1, m_s2, m_q, m_w, m_pulse, m_retry, m_loss;
  bit m_failed, m_valid;

  always @(posedge clkin) begin
    int ls;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_q = 0; m_w = 0; m_pulse = P;
      m_retry = 0; m_loss = 0; m_failed = 0; m_valid = 1;
    end else begin
      ls = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(lock_i);
      if (!m_failed) begin
        if (m_pulse > 0) begin
          m_pulse--;
        end else if (ls != 0) begin
          if (m_q < 1000000) m_q++;
          if (m_q == S + 1 + T) m_retry = 0;
        end else if (m_q > 0) begin
          if (m_q >= S + 1 && m_loss < 255) m_loss++;
          m_q = 0;
          m_w = 0;
        end else begin
          m_w++;
          if (m_w == TO) begin
            m_w = 0;
            if (m_retry < 15) m_retry++;
            if (m_retry == MAXR) m_failed = 1;
            else m_pulse = P;
          end
        end
      end
    end
  end

  always @(negedge clkin) begin
    int exp_loss;
    if (!reset && m_valid) begin
`ifdef TMDS_PLL_RST_SEQ_LOSS_CNT_EN
      exp_loss = m_loss;
`else
      exp_loss = 0;
`endif
      chk("pll_rst", int'(pll_rst_o), int'(!m_failed && m_pulse > 0));
      chk("ser_rst", int'(ser_rst_o), int'(m_q < S + 1));
      chk("pix_rst", int'(pix_rst_o), int'(m_q < S + 1 + T));
      chk("ready", int'(ready_o), int'(m_q >= S + 1 + T));
      chk("fail", int'(fail_o), int'(m_failed));
      chk("retry_cnt", int'(retry_cnt_o), m_retry);
      chk("lock_loss_cnt", int'(lock_loss_cnt_o), exp_loss);
      chk("pix_before_ser", int'(!pix_rst_o && ser_rst_o), 0);
      chk("pll_and_ready", int'(pll_rst_o && ready_o), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_pll", int'(pll_rst_o), 1);
    chk("rst_ser", int'(ser_rst_o), 1);
    chk("rst_pix", int'(pix_rst_o), 1);
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_fail", int'(fail_o), 0);
    chk("rst_retry", int'(retry_cnt_o), 0);
    chk("rst_loss", int'(lock_loss_cnt_o), 0);
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int saw;
    tick(1);

    // Power-up: pulse width, lock-to-release latency, ser-to-pix gap.
    do_reset();
    n = 0;
    while (pll_rst_o && n < 100) begin tick(1); n++; end
    chk("pulse_width", n, P);
    tick(10);
    lock_i = 1'b1;
    n = 0;
    while (ser_rst_o && n < 1000) begin tick(1); n++; end
    chk("lock_to_ser", n, 2 + S + 1);
    n = 0;
    while (pix_rst_o && n < 1000) begin tick(1); n++; end
    chk("ser_to_pix", n, T);
    chk("ready_up", int'(ready_o), 1);
    chk("retry_run", int'(retry_cnt_o), 0);

    // Lock loss in RUN.
    tick(10);
    lock_i = 1'b0;
    n = 0;
    while (ready_o && n < 100) begin tick(1); n++; end
    chk("drop_to_ready_low", n, 3);
    chk("drop_ser", int'(ser_rst_o), 1);
    chk("drop_pix", int'(pix_rst_o), 1);
    tick(7);
    lock_i = 1'b1;
    n = 0;
    while (!ready_o && n < 1000) begin tick(1); n++; end
    chk("rerelease", n, 2 + S + 1 + T);
`ifdef TMDS_PLL_RST_SEQ_LOSS_CNT_EN
    chk("loss_cnt_one", int'(lock_loss_cnt_o), 1);
`else
    chk("loss_cnt_zero", int'(lock_loss_cnt_o), 0);
`endif

    // Glitch during STABLE: re-qualify without a PLL reset.
    lock_i = 1'b0;
    do_reset();
    tick(P + 2);
    lock_i = 1'b1;
    tick(13);
    lock_i = 1'b0;
    tick(3);
    lock_i = 1'b1;
    n = 0;
    saw = 0;
    while (ser_rst_o && n < 1000) begin
      tick(1);
      n++;
      if (pll_rst_o) saw = 1;
    end
    chk("glitch_to_ser", n, 2 + S + 1);
    chk("glitch_no_pll", saw, 0);

    // Reset asserted in REL_SER with cnt=4.
    tick(4);
    chk("relser_pix_held", int'(pix_rst_o), 1);
    do_reset();
    n = 0;
    while (pll_rst_o && n < 100) begin tick(1); n++; end
    chk("restart_pulse", n, P);

    // Lock never arrives: fail after MAXR timeouts.
    lock_i = 1'b0;
    do_reset();
    n = 0;
    while (!fail_o && n < 2000) begin tick(1); n++; end
    chk("fail_time", n, MAXR * (P + TO));
    chk("fail_retry", int'(retry_cnt_o), MAXR);
    chk("fail_pll", int'(pll_rst_o), 0);
    chk("fail_ser", int'(ser_rst_o), 1);
    tick(50);
    chk("fail_sticky", int'(fail_o), 1);

    // Two timeouts then lock.
    do_reset();
    tick(2 * (P + TO) + P + 5);
    chk("two_to_retry", int'(retry_cnt_o), 2);
    lock_i = 1'b1;
    tick(5);
    chk("stable_retry", int'(retry_cnt_o), 2);
    n = 0;
    while (!ready_o && n < 1000) begin tick(1); n++; end
    chk("two_to_ready", int'(ready_o), 1);
    chk("two_to_cleared", int'(retry_cnt_o), 0);
    chk("two_to_nofail", int'(fail_o), 0);

    // Randomized lock behaviour with occasional resets.
    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        lock_i = 1'($urandom_range(0, 1));
        do_reset();
      end else if (r < 4) begin
        lock_i = 1'b0;
        tick(int'($urandom_range(40, 200)));
      end else if (r < 11) begin
        lock_i = 1'b0;
        tick(int'($urandom_range(1, 4)));
      end else begin
        lock_i = 1'b1;
        tick(int'($urandom_range(1, 60)));
      end
    end

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
